vlan_sync_detect: RTL and testbench

- Parametrised successor to the single-stream VLAN sync detector in the 250 MHz user-logic box.
- Passively monitors N AXI-Stream ports and detects first beats carrying a VLAN tag (TPID 0x8100 or 0x88A8) whose VID equals a runtime-configurable value.
- Emits registered per-stream sync pulses with per-stream hold-off, a timestamp capture and saturating statistics counters for the clock-sync logic.

---
 rtl/vlan_sync_pkg.sv | 31 +++
 rtl/vlan_sync_detect_match.sv | 109 ++++++++++
 rtl/vlan_sync_detect.sv | 105 ++++++++++
 tb/tb_vlan_sync_detect.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vlan_sync_pkg.sv
// -----------------------------------------------------------------------------
// vlan_sync_pkg
// Shared constants, the per-stream FSM state type and a byte-extraction helper
// for the VLAN sync detector.
//   TPID_8100 / TPID_88A8 : accepted tag protocol identifiers
//   ETH_TYPE_BYTE         : byte offset of the TPID in the first beat
//   VID_BYTE              : byte offset of the TCI (PCP/DEI/VID) in the first beat
//   in_state_e            : per-stream packet tracking state
//   lane_byte()           : returns byte k of a 512-bit data lane
// -----------------------------------------------------------------------------
package vlan_sync_pkg;

    localparam logic [15:0] TPID_8100     = 16'h8100;
    localparam logic [15:0] TPID_88A8     = 16'h88A8;
    localparam int          ETH_TYPE_BYTE = 12;
    localparam int          VID_BYTE      = 14;
    localparam int          LANE_W        = 512;
    localparam int          KEEP_W        = 64;
    localparam int          USER_W        = 16;

    typedef enum logic {
        IN_IDLE = 1'b0,
        IN_PKT  = 1'b1
    } in_state_e;

    // Byte k sits at bits [8k+:8] of the lane (byte 0 is first on the wire).
    function automatic logic [7:0] lane_byte(input logic [LANE_W-1:0] lane, input int k);
        return lane[8*k +: 8];
    endfunction

endpackage

// File: rtl/vlan_sync_detect_match.sv
// -----------------------------------------------------------------------------
// vlan_first_beat_match
// Per-stream first-beat tracker and VLAN tag matcher with hold-off and
// saturating statistics counters.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IN_IDLE | waiting for a packet; the next transfer is a first beat
// IN_PKT  | inside a packet; transfers are ignored until tlast
//
// Ports:
//   aclk, aresetn   clock, asynchronous active-low reset
//   tvalid, tready  transfer qualifiers of the monitored stream
//   tdata, tkeep    beat payload and byte enables
//   tlast           end of packet
//   cfg_enable      enables matching
//   cfg_vlan_id     VID to match
//   cfg_holdoff     suppression window loaded on each detection
//   det_o           raw (combinational) detect for this cycle's beat
//   det_cnt_o       saturating count of detections
//   supp_cnt_o      saturating count of matches suppressed by hold-off
// -----------------------------------------------------------------------------
module vlan_first_beat_match
    import vlan_sync_pkg::*;
#(
    parameter int CNT_W     = 32,
    parameter int HOLDOFF_W = 16
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 tvalid,
    input  logic                 tready,
    input  logic [LANE_W-1:0]    tdata,
    input  logic [KEEP_W-1:0]    tkeep,
    input  logic                 tlast,
    input  logic                 cfg_enable,
    input  logic [11:0]          cfg_vlan_id,
    input  logic [HOLDOFF_W-1:0] cfg_holdoff,
    output logic                 det_o,
    output logic [CNT_W-1:0]     det_cnt_o,
    output logic [CNT_W-1:0]     supp_cnt_o
);

    in_state_e            state;
    logic [HOLDOFF_W-1:0] holdoff_cnt;

    logic        xfer;
    logic        first_beat;
    logic [15:0] eth_type;
    logic [7:0]  tci_hi;
    logic [7:0]  tci_lo;
    logic        keep_ok;
    logic        tpid_ok;
    logic        vid_ok;
    logic        match;
    logic        suppress;

    assign xfer       = tvalid & tready;
    assign first_beat = xfer & (state == IN_IDLE);

    assign eth_type = {lane_byte(tdata, ETH_TYPE_BYTE), lane_byte(tdata, ETH_TYPE_BYTE + 1)};
    assign tci_hi   = lane_byte(tdata, VID_BYTE);
    assign tci_lo   = lane_byte(tdata, VID_BYTE + 1);

    // Bytes 0..15 must all be present; a truncated beat cannot carry a full tag.
    assign keep_ok = &tkeep[15:0];
    assign tpid_ok = (eth_type == TPID_8100) || (eth_type == TPID_88A8);
    // PCP/DEI live in the upper nibble of the TCI and are deliberately ignored.
    assign vid_ok  = ({tci_hi[3:0], tci_lo} == cfg_vlan_id);

    assign match    = first_beat & keep_ok & tpid_ok & vid_ok & cfg_enable;
    assign det_o    = match & (holdoff_cnt == '0);
    assign suppress = match & (holdoff_cnt != '0);

    logic unused_bits;
    assign unused_bits = ^{tdata[LANE_W-1:128], tkeep[KEEP_W-1:16], tci_hi[7:4]};

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= IN_IDLE;
            holdoff_cnt <= '0;
            det_cnt_o   <= '0;
            supp_cnt_o  <= '0;
        end else begin
            if (xfer) begin
                case (state)
                    IN_IDLE: state <= tlast ? IN_IDLE : IN_PKT;
                    IN_PKT:  state <= tlast ? IN_IDLE : IN_PKT;
                    default: state <= IN_IDLE;
                endcase
            end

            if (det_o) begin
                holdoff_cnt <= cfg_holdoff;
            end else if (holdoff_cnt != '0) begin
                holdoff_cnt <= holdoff_cnt - HOLDOFF_W'(1);
            end

            if (det_o && (det_cnt_o != {CNT_W{1'b1}})) begin
                det_cnt_o <= det_cnt_o + CNT_W'(1);
            end

            if (suppress && (supp_cnt_o != {CNT_W{1'b1}})) begin
                supp_cnt_o <= supp_cnt_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/vlan_sync_detect.sv
// -----------------------------------------------------------------------------
// vlan_sync_detect
// Passive monitor of NUM_AXI_STREAM AXI-Stream ports. Detects first beats that
// carry a VLAN tag with a configured VID and produces registered sync pulses,
// a shared detection timestamp and per-stream statistics.
//
// Ports:
//   aclk, aresetn    clock, asynchronous active-low reset
//   s_axis_*         monitored stream signals (tready is an input: observed only)
//   cfg_enable       0 disables all detection
//   cfg_vlan_id      VID to match
//   cfg_holdoff      per-stream suppression window after a detection
//   sync_pulse_o     one-cycle pulse per detecting stream
//   sync_any_o       OR of sync_pulse_o
//   sync_src_o       lowest-index stream pulsing this cycle (0 when none)
//   sync_ts_o        timestamp of the last detecting beat
//   det_cnt_o        per-stream detection counts, CNT_W each
//   supp_cnt_o       per-stream suppressed-match counts, CNT_W each
// -----------------------------------------------------------------------------
module vlan_sync_detect
    import vlan_sync_pkg::*;
#(
    parameter int NUM_AXI_STREAM = 2,
    parameter int TS_W           = 64,
    parameter int CNT_W          = 32,
    parameter int HOLDOFF_W      = 16,
    localparam int SRC_W         = (NUM_AXI_STREAM > 1) ? $clog2(NUM_AXI_STREAM) : 1
) (
    input  logic                               aclk,
    input  logic                               aresetn,
    input  logic [NUM_AXI_STREAM-1:0]          s_axis_tvalid,
    input  logic [LANE_W*NUM_AXI_STREAM-1:0]   s_axis_tdata,
    input  logic [KEEP_W*NUM_AXI_STREAM-1:0]   s_axis_tkeep,
    input  logic [NUM_AXI_STREAM-1:0]          s_axis_tlast,
    input  logic [USER_W*NUM_AXI_STREAM-1:0]   s_axis_tuser,
    input  logic [NUM_AXI_STREAM-1:0]          s_axis_tready,
    input  logic                               cfg_enable,
    input  logic [11:0]                        cfg_vlan_id,
    input  logic [HOLDOFF_W-1:0]               cfg_holdoff,
    output logic [NUM_AXI_STREAM-1:0]          sync_pulse_o,
    output logic                               sync_any_o,
    output logic [SRC_W-1:0]                   sync_src_o,
    output logic [TS_W-1:0]                    sync_ts_o,
    output logic [CNT_W*NUM_AXI_STREAM-1:0]    det_cnt_o,
    output logic [CNT_W*NUM_AXI_STREAM-1:0]    supp_cnt_o
);

    logic [TS_W-1:0]           ts_cnt;
    logic [NUM_AXI_STREAM-1:0] det_raw;
    logic [SRC_W-1:0]          src_next;

    logic unused_user;
    assign unused_user = ^s_axis_tuser;

    for (genvar i = 0; i < NUM_AXI_STREAM; i++) begin : g_stream
        vlan_first_beat_match #(
            .CNT_W     (CNT_W),
            .HOLDOFF_W (HOLDOFF_W)
        ) u_match (
            .aclk        (aclk),
            .aresetn     (aresetn),
            .tvalid      (s_axis_tvalid[i]),
            .tready      (s_axis_tready[i]),
            .tdata       (s_axis_tdata[LANE_W*i +: LANE_W]),
            .tkeep       (s_axis_tkeep[KEEP_W*i +: KEEP_W]),
            .tlast       (s_axis_tlast[i]),
            .cfg_enable  (cfg_enable),
            .cfg_vlan_id (cfg_vlan_id),
            .cfg_holdoff (cfg_holdoff),
            .det_o       (det_raw[i]),
            .det_cnt_o   (det_cnt_o[CNT_W*i +: CNT_W]),
            .supp_cnt_o  (supp_cnt_o[CNT_W*i +: CNT_W])
        );
    end

    // Scan from the top down so the lowest detecting index wins.
    always_comb begin
        src_next = '0;
        for (int i = NUM_AXI_STREAM - 1; i >= 0; i--) begin
            if (det_raw[i]) begin
                src_next = SRC_W'(i);
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ts_cnt       <= '0;
            sync_pulse_o <= '0;
            sync_any_o   <= 1'b0;
            sync_src_o   <= '0;
            sync_ts_o    <= '0;
        end else begin
            ts_cnt       <= ts_cnt + TS_W'(1);
            sync_pulse_o <= det_raw;
            sync_any_o   <= |det_raw;
            sync_src_o   <= src_next;
            // ts_cnt still holds the matching beat's cycle value here.
            if (|det_raw) begin
                sync_ts_o <= ts_cnt;
            end
        end
    end

endmodule

// File: tb/tb_vlan_sync_detect.sv
module tb_vlan_sync_detect;

    localparam int N       = 2;
    localparam int TS_W    = 64;
    localparam int CNT_W   = 4;
    localparam int HO_W    = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic               aclk = 1'b0;
    logic               aresetn;
    logic [N-1:0]       s_axis_tvalid;
    logic [512*N-1:0]   s_axis_tdata;
    logic [64*N-1:0]    s_axis_tkeep;
    logic [N-1:0]       s_axis_tlast;
    logic [16*N-1:0]    s_axis_tuser;
    logic [N-1:0]       s_axis_tready;
    logic               cfg_enable;
    logic [11:0]        cfg_vlan_id;
    logic [HO_W-1:0]    cfg_holdoff;
    logic [N-1:0]       sync_pulse_o;
    logic               sync_any_o;
    logic [0:0]         sync_src_o;
    logic [TS_W-1:0]    sync_ts_o;
    logic [CNT_W*N-1:0] det_cnt_o;
    logic [CNT_W*N-1:0] supp_cnt_o;

    vlan_sync_detect #(
        .NUM_AXI_STREAM (N),
        .TS_W           (TS_W),
        .CNT_W          (CNT_W),
        .HOLDOFF_W      (HO_W)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tready (s_axis_tready),
        .cfg_enable    (cfg_enable),
        .cfg_vlan_id   (cfg_vlan_id),
        .cfg_holdoff   (cfg_holdoff),
        .sync_pulse_o  (sync_pulse_o),
        .sync_any_o    (sync_any_o),
        .sync_src_o    (sync_src_o),
        .sync_ts_o     (sync_ts_o),
        .det_cnt_o     (det_cnt_o),
        .supp_cnt_o    (supp_cnt_o)
    );

    always #5 aclk = ~aclk;

    int n_cmp = 0;
    int n_err = 0;
    bit check_en = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Packet position is tracked per stream; a match is suppressed when the
    // cycle distance to the previous detection is within that detection's
    // hold-off value.
    logic [63:0] m_ts;
    logic [N-1:0] m_pulse;
    int          m_src;
    logic [63:0] m_sync_ts;
    bit          m_in_pkt  [N];
    bit          m_has_det [N];
    logic [63:0] m_last_det[N];
    int          m_last_hold[N];
    int          m_det     [N];
    int          m_supp    [N];

    function automatic bit tag_matches(input logic [511:0] d, input logic [63:0] k,
                                       input logic en, input logic [11:0] vid);
        logic [15:0] tpid;
        logic [11:0] fvid;
        tpid = {d[12*8 +: 8], d[13*8 +: 8]};
        fvid = {d[14*8 +: 4], d[15*8 +: 8]};
        return en && (k[15:0] == 16'hFFFF) && (tpid == 16'h8100 || tpid == 16'h88A8) && (fvid == vid);
    endfunction

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_ts = '0;
            m_pulse = '0;
            m_src = 0;
            m_sync_ts = '0;
            for (int i = 0; i < N; i++) begin
                m_in_pkt[i] = 1'b0;
                m_has_det[i] = 1'b0;
                m_last_det[i] = '0;
                m_last_hold[i] = 0;
                m_det[i] = 0;
                m_supp[i] = 0;
            end
        end else begin
            m_pulse = '0;
            m_src = 0;
            for (int i = 0; i < N; i++) begin
                if (s_axis_tvalid[i] && s_axis_tready[i]) begin
                    if (!m_in_pkt[i] && tag_matches(s_axis_tdata[512*i +: 512], s_axis_tkeep[64*i +: 64],
                                                    cfg_enable, cfg_vlan_id)) begin
                        if (m_has_det[i] && (m_ts - m_last_det[i]) <= 64'(m_last_hold[i])) begin
                            if (m_supp[i] < CNT_MAX) m_supp[i]++;
                        end else begin
                            m_pulse[i] = 1'b1;
                            if (m_det[i] < CNT_MAX) m_det[i]++;
                            m_has_det[i] = 1'b1;
                            m_last_det[i] = m_ts;
                            m_last_hold[i] = int'(cfg_holdoff);
                        end
                    end
                    m_in_pkt[i] = !s_axis_tlast[i];
                end
            end
            for (int i = N - 1; i >= 0; i--) begin
                if (m_pulse[i]) m_src = i;
            end
            if (m_pulse != '0) m_sync_ts = m_ts;
            m_ts = m_ts + 64'd1;
        end
    end

    always @(negedge aclk) begin
        if (check_en) begin
            check("sync_pulse", 64'(sync_pulse_o), 64'(m_pulse));
            check("sync_any", 64'(sync_any_o), 64'(m_pulse != '0));
            check("sync_src", 64'(sync_src_o), 64'(m_src));
            check("sync_ts", sync_ts_o, m_sync_ts);
            for (int i = 0; i < N; i++) begin
                check($sformatf("det_cnt%0d", i), 64'(det_cnt_o[CNT_W*i +: CNT_W]), 64'(m_det[i]));
                check($sformatf("supp_cnt%0d", i), 64'(supp_cnt_o[CNT_W*i +: CNT_W]), 64'(m_supp[i]));
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [511:0] frame(input logic [15:0] tpid, input logic [3:0] pcp,
                                           input logic [11:0] vid);
        logic [511:0] d;
        for (int k = 0; k < 64; k++) d[8*k +: 8] = 8'(k + 8'h40);
        d[12*8 +: 8] = tpid[15:8];
        d[13*8 +: 8] = tpid[7:0];
        d[14*8 +: 8] = {pcp, vid[11:8]};
        d[15*8 +: 8] = vid[7:0];
        return d;
    endfunction

    task automatic put(input int s, input logic [511:0] d, input logic [63:0] k,
                       input logic l, input logic r);
        s_axis_tvalid[s] = 1'b1;
        s_axis_tready[s] = r;
        s_axis_tdata[512*s +: 512] = d;
        s_axis_tkeep[64*s +: 64] = k;
        s_axis_tlast[s] = l;
    endtask

    task automatic clr();
        s_axis_tvalid = '0;
        s_axis_tready = '1;
        s_axis_tlast = '0;
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    localparam logic [63:0] KALL  = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] KSHRT = 64'hFFFF_FFFF_FFFF_7FFF;

    logic [511:0] good;

    initial begin
        aresetn = 1'b1;
        s_axis_tdata = '0;
        s_axis_tkeep = '0;
        s_axis_tuser = '0;
        cfg_enable = 1'b1;
        cfg_vlan_id = 12'hABC;
        cfg_holdoff = '0;
        clr();
        good = frame(16'h8100, 4'h0, 12'hABC);
        #1 aresetn = 1'b0;
        #1 check_en = 1'b1;
        tick(3);
        check("reset_pulse", 64'(sync_pulse_o), 64'h0);
        check("reset_det", 64'(det_cnt_o), 64'h0);
        aresetn = 1'b1;
        tick(2);

        // basic match on stream 0
        put(0, good, KALL, 1'b1, 1'b1);
        tick();
        clr();
        check("basic_pulse", 64'(sync_pulse_o), 64'h1);
        check("basic_src", 64'(sync_src_o), 64'h0);
        check("basic_det0", 64'(det_cnt_o[3:0]), 64'h1);
        tick();
        check("basic_pulse_end", 64'(sync_pulse_o), 64'h0);

        // negatives: wrong VID, wrong TPID, short beat, detector disabled
        put(0, frame(16'h8100, 4'h0, 12'hABD), KALL, 1'b1, 1'b1); tick(); clr();
        check("neg_vid", 64'(sync_pulse_o), 64'h0);
        put(0, frame(16'h0800, 4'h0, 12'hABC), KALL, 1'b1, 1'b1); tick(); clr();
        check("neg_tpid", 64'(sync_pulse_o), 64'h0);
        put(0, good, KSHRT, 1'b1, 1'b1); tick(); clr();
        check("neg_keep", 64'(sync_pulse_o), 64'h0);
        cfg_enable = 1'b0;
        put(0, good, KALL, 1'b1, 1'b1); tick(); clr();
        check("neg_enable", 64'(sync_pulse_o), 64'h0);
        cfg_enable = 1'b1;
        check("neg_det0", 64'(det_cnt_o[3:0]), 64'h1);
        tick();

        // 3-beat packet, first beat stalled two cycles, later beats also tagged
        put(0, frame(16'h8100, 4'hE, 12'hABC), KALL, 1'b0, 1'b0); tick(2);
        check("stall_pulse", 64'(sync_pulse_o), 64'h0);
        s_axis_tready[0] = 1'b1; tick();
        check("pkt_pulse", 64'(sync_pulse_o), 64'h1);
        put(0, good, KALL, 1'b0, 1'b1); tick();
        check("pkt_beat2", 64'(sync_pulse_o), 64'h0);
        put(0, good, KALL, 1'b1, 1'b1); tick(); clr();
        check("pkt_beat3", 64'(sync_pulse_o), 64'h0);
        check("pkt_det0", 64'(det_cnt_o[3:0]), 64'h2);
        tick();

        // hold-off on stream 1: frames at relative cycles 0, 5, 12
        cfg_holdoff = 16'd10;
        put(1, good, KALL, 1'b1, 1'b1); tick(); clr();
        check("ho_first", 64'(sync_pulse_o), 64'h2);
        tick(4);
        put(1, good, KALL, 1'b1, 1'b1); tick(); clr();
        check("ho_supp_pulse", 64'(sync_pulse_o), 64'h0);
        check("ho_supp1", 64'(supp_cnt_o[7:4]), 64'h1);
        tick(6);
        put(1, good, KALL, 1'b1, 1'b1); tick(); clr();
        check("ho_third", 64'(sync_pulse_o), 64'h2);
        check("ho_src", 64'(sync_src_o), 64'h1);
        check("ho_det1", 64'(det_cnt_o[7:4]), 64'h2);
        cfg_holdoff = '0;
        tick(12);

        // simultaneous detection with 88A8
        put(0, frame(16'h88A8, 4'h5, 12'hABC), KALL, 1'b1, 1'b1);
        put(1, frame(16'h88A8, 4'h5, 12'hABC), KALL, 1'b1, 1'b1);
        tick(); clr();
        check("both_pulse", 64'(sync_pulse_o), 64'h3);
        check("both_any", 64'(sync_any_o), 64'h1);
        check("both_src", 64'(sync_src_o), 64'h0);
        tick();

        // saturation: 20 back-to-back single-beat matches on stream 0
        for (int j = 0; j < 20; j++) begin
            put(0, good, KALL, 1'b1, 1'b1);
            tick();
        end
        clr();
        check("sat_det0", 64'(det_cnt_o[3:0]), 64'hF);
        tick();

        // reset in the middle of a packet on stream 1
        put(1, frame(16'h0800, 4'h0, 12'hABC), KALL, 1'b0, 1'b1); tick(); clr();
        tick();
        aresetn = 1'b0;
        tick(2);
        check("rst_det0", 64'(det_cnt_o[3:0]), 64'h0);
        check("rst_ts", sync_ts_o, 64'h0);
        aresetn = 1'b1;
        tick();
        put(1, good, KALL, 1'b1, 1'b1); tick(); clr();
        check("rst_first_beat", 64'(sync_pulse_o), 64'h2);
        check("rst_det1", 64'(det_cnt_o[7:4]), 64'h1);
        tick(3);

        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
